// File: rtl/spi_txn_pkg.sv
// spi_txn_pkg: shared types and constants for the SPI
// transaction controller.
package spi_txn_pkg;

  localparam logic [6:0] ADDR_ID     = 7'h00;
  localparam logic [6:0] ADDR_TEMP   = 7'h01;
  localparam logic [6:0] ADDR_LIMIT  = 7'h02;
  localparam logic [6:0] ADDR_STATUS = 7'h03;

  localparam logic [4:0] FRAME_BITS = 5'd16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    COMMIT,
    ERR
  } state_t;

  // Reads may hit any mapped register; writes only RW ones.
  function automatic logic frame_legal(
    input logic       rw,
    input logic [6:0] addr
  );
    if (rw)
      return addr <= ADDR_STATUS;
    return (addr == ADDR_TEMP) ||
           (addr == ADDR_LIMIT) ||
           (addr == ADDR_STATUS);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with registered
// level and edge strobes.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES:0] sr;

  // Synchronizer chain; top bit holds the previous level.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      sr <= '0;
    else
      sr <= {sr[STAGES-1:0], d};
  end

  // Registered strobes keep level and edges aligned.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= sr[STAGES-1];
      rise  <= sr[STAGES-1] & ~sr[STAGES];
      fall  <= ~sr[STAGES-1] & sr[STAGES];
    end
  end

endmodule

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: mode-0 SPI slave frame decoder with
// register bank, error counter and status LEDs.
module spi_txn_ctrl
  import spi_txn_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID     = 8'hA5,
  parameter logic [7:0] LIMIT_DEFAULT = 8'd30,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [1:0] led,
  output logic [7:0] temp_q,
  output logic [7:0] limit_q,
  output logic [7:0] err_cnt,
  output logic       frame_ok
);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES:0] mosi_dl;
  logic mosi_s;

  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] so_q;
  logic [7:0] rd_val;
  logic       rw_q;
  logic [6:0] addr_q;
  logic       hdr_ld;
  logic       commit_ok, commit_err;
  logic       last_ok;
  logic       miso_ld, miso_sh;
  logic       unused_lvl;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (spi_sck),
    .level  (sck_lvl),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (spi_cs),
    .level  (cs_lvl),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  assign unused_lvl = sck_lvl ^ cs_lvl;
  assign mosi_s     = mosi_dl[SYNC_STAGES];

  // MOSI delay matched to the SCK strobe latency.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      mosi_dl <= '0;
    else
      mosi_dl <= {mosi_dl[SYNC_STAGES-1:0], spi_mosi};
  end

  // Frame FSM: next state, shift-in and commit strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    hdr_ld     = 1'b0;
    commit_ok  = 1'b0;
    commit_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (cs_rise) begin
          commit_err = 1'b1;
          state_d    = IDLE;
        end else if (sck_rise) begin
          sh_d  = {sh_q[6:0], mosi_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            hdr_ld  = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          if (cnt_q == FRAME_BITS) begin
            state_d = COMMIT;
          end else begin
            commit_err = 1'b1;
            state_d    = IDLE;
          end
        end else if (sck_rise) begin
          if (cnt_q == FRAME_BITS) begin
            state_d = ERR;
          end else begin
            sh_d  = {sh_q[6:0], mosi_s};
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (frame_legal(rw_q, addr_q))
          commit_ok = 1'b1;
        else
          commit_err = 1'b1;
      end
      ERR: begin
        if (cs_rise) begin
          commit_err = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, bit counter, shift-in and header latch.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      if (hdr_ld)
        {rw_q, addr_q} <= sh_d;
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      addr_q == ADDR_ID:     rd_val = DEVICE_ID;
      addr_q == ADDR_TEMP:   rd_val = temp_q;
      addr_q == ADDR_LIMIT:  rd_val = limit_q;
      addr_q == ADDR_STATUS: rd_val = err_cnt;
      default:               rd_val = '0;
    endcase
  end

  assign miso_ld = (state_q == DATA) && rw_q && sck_fall &&
                   !cs_rise && (cnt_q == 5'd8);
  assign miso_sh = (state_q == DATA) && rw_q && sck_fall &&
                   !cs_rise && (cnt_q != 5'd8);

  // MISO shifter: load on first fall of byte1, then shift.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      so_q     <= '0;
      spi_miso <= 1'b0;
    end else if (state_d != DATA || !rw_q) begin
      so_q     <= '0;
      spi_miso <= 1'b0;
    end else if (miso_ld) begin
      so_q     <= rd_val;
      spi_miso <= rd_val[7];
    end else if (miso_sh) begin
      so_q     <= {so_q[6:0], 1'b0};
      spi_miso <= so_q[6];
    end
  end

  // Register bank, error counter and frame status.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      temp_q   <= '0;
      limit_q  <= LIMIT_DEFAULT;
      err_cnt  <= '0;
      last_ok  <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      frame_ok <= commit_ok;
      if (commit_err) begin
        last_ok <= 1'b0;
        if (err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end else if (commit_ok) begin
        last_ok <= 1'b1;
        if (!rw_q) begin
          if (addr_q == ADDR_TEMP)
            temp_q <= sh_q;
          if (addr_q == ADDR_LIMIT)
            limit_q <= sh_q;
          if (addr_q == ADDR_STATUS)
            err_cnt <= '0;
        end
      end
    end
  end

  // Active-low LEDs, registered off the bank outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      led <= 2'b11;
    else
      led <= {~last_ok, ~(temp_q > limit_q)};
  end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb_spi_txn_ctrl: directed frame-level checks of
// spi_txn_ctrl using a bit-banged mode-0 master.
module tb_spi_txn_ctrl;

  localparam int HALF = 5;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [1:0] led;
  logic [7:0] temp_q;
  logic [7:0] limit_q;
  logic [7:0] err_cnt;
  logic       frame_ok;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  logic [7:0] rd_byte;

  spi_txn_ctrl dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .spi_cs   (spi_cs),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .led      (led),
    .temp_q   (temp_q),
    .limit_q  (limit_q),
    .err_cnt  (err_cnt),
    .frame_ok (frame_ok)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in)
    if (frame_ok === 1'b1)
      pulses <= pulses + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(14);
  endtask

  task automatic shift_bits(input logic [31:0] bits,
                            input int n,
                            input int first);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      wait_clk(HALF);
      if (first + (n - 1 - i) >= 8 &&
          first + (n - 1 - i) < 16)
        rd_byte = {rd_byte[6:0], spi_miso};
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [31:0] bits, input int n);
    rd_byte = '0;
    cs_low();
    shift_bits(bits, n, 0);
    cs_high();
  endtask

  initial begin
    wait_clk(4);
    check("rst_miso", spi_miso, 0);
    check("rst_led", led, 2'b11);
    check("rst_temp", temp_q, 8'h00);
    check("rst_limit", limit_q, 8'd30);
    check("rst_err", err_cnt, 8'h00);
    check("rst_frame_ok", frame_ok, 0);
    rst = 1'b1;
    wait_clk(10);
    check("idle_pulses", pulses, 0);

    xfer(32'h0120, 16);
    check("w_temp", temp_q, 8'h20);
    check("w_temp_pulse", pulses, 1);
    xfer(32'h021E, 16);
    check("w_limit", limit_q, 8'h1E);
    check("w_limit_pulse", pulses, 2);
    check("led_both_on", led, 2'b00);

    xfer(32'h8000, 16);
    check("r_id_miso", rd_byte, 8'hA5);
    check("r_id_temp", temp_q, 8'h20);
    check("r_id_led1", led[1], 1'b0);
    check("r_id_pulse", pulses, 3);

    xfer(32'h015, 12);
    check("short_temp", temp_q, 8'h20);
    check("short_err", err_cnt, 8'd1);
    check("short_led1", led[1], 1'b1);
    check("short_pulse", pulses, 3);

    xfer({15'h0, 16'h0177, 1'b1}, 17);
    check("long_temp", temp_q, 8'h20);
    check("long_err", err_cnt, 8'd2);
    xfer(32'h0300, 16);
    check("clr_err", err_cnt, 8'd0);
    check("clr_pulse", pulses, 4);
    check("clr_led1", led[1], 1'b0);

    xfer(32'h0012, 16);
    check("w_id_err", err_cnt, 8'd1);
    xfer(32'h1034, 16);
    check("w_unmap_err", err_cnt, 8'd2);
    check("w_bad_temp", temp_q, 8'h20);
    check("w_bad_limit", limit_q, 8'h1E);
    xfer(32'h9000, 16);
    check("r_unmap_miso", rd_byte, 8'h00);
    check("r_unmap_err", err_cnt, 8'd3);
    check("r_unmap_pulse", pulses, 4);
    check("r_unmap_led1", led[1], 1'b1);

    xfer(32'h81FF, 16);
    check("r_temp_miso", rd_byte, 8'h20);
    check("r_temp_err", err_cnt, 8'd3);
    xfer(32'h8300, 16);
    check("r_status_miso", rd_byte, 8'h03);
    check("r_status_pulse", pulses, 6);

    xfer(32'h0280, 16);
    check("lim80_led", led, 2'b01);
    xfer(32'h0181, 16);
    check("temp81_led", led, 2'b00);
    check("temp81_pulse", pulses, 8);

    for (int k = 0; k < 260; k++) begin
      spi_cs = 1'b0;
      wait_clk(6);
      spi_cs = 1'b1;
      wait_clk(8);
    end
    check("err_saturate", err_cnt, 8'hFF);
    check("sat_temp", temp_q, 8'h81);

    rd_byte = '0;
    cs_low();
    shift_bits(32'h01A, 12, 0);
    rst = 1'b0;
    wait_clk(3);
    check("mid_rst_temp", temp_q, 8'h00);
    check("mid_rst_limit", limit_q, 8'd30);
    check("mid_rst_err", err_cnt, 8'h00);
    check("mid_rst_led", led, 2'b11);
    check("mid_rst_miso", spi_miso, 0);
    check("mid_rst_fok", frame_ok, 0);
    rst = 1'b1;
    wait_clk(2);
    shift_bits(32'hB, 4, 12);
    cs_high();
    check("post_rst_temp", temp_q, 8'h00);
    check("post_rst_err", err_cnt, 8'h00);
    check("post_rst_pulse", pulses, 8);

    xfer(32'h0177, 16);
    check("after_rst_temp", temp_q, 8'h77);
    check("after_rst_pulse", pulses, 9);
    check("after_rst_led", led, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
